// File: rtl/serial_link_pkg.sv
// Shared definitions for both ends of the bidirectional shift-register serial link.
// Frame on the wire: start '1', data bits, optional parity bit, stop '0'; idle line is 0.
package serial_link_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } serial_state_e;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;
    localparam logic START_BIT     = 1'b1;
    localparam logic STOP_BIT      = 1'b0;

    // acc is the XOR of all data bits; odd selects the required sense of data+parity.
    function automatic logic parity_mismatch(input logic acc, input logic par_bit, input logic odd);
        return (acc ^ par_bit) != odd;
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit serial-in/parallel-out shift register holding the word being assembled.
// dir=LSB-first shifts in at the MSB (moving right); dir=MSB-first shifts in at the LSB.
module sipo_shift_core
    import serial_link_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (shift_en) begin
            if (dir == DIR_MSB_FIRST) begin
                q_d = {q_q[WIDTH-2:0], sin};
            end else begin
                q_d = {sin, q_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/serial_word_deserializer.sv
// Receive end of the serial link: frames the sin_en-strobed bit stream into WIDTH-bit words
// on a valid/ready output. Optional parity bit after the data when SERIAL_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a start bit; dir is latched when it arrives
// DATA   | shifting in WIDTH data bits
// PARITY | sampling the parity bit (SERIAL_PARITY_EN builds only)
// STOP   | sampling the stop bit; a good stop delivers the word
module serial_word_deserializer
    import serial_link_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int PAR_ODD = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             dir,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
    output logic             par_err,
    output logic             overrun,
    input  logic             err_clr
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef SERIAL_PARITY_EN
    localparam serial_state_e AFTER_DATA = PARITY;
`else
    localparam serial_state_e AFTER_DATA = STOP;
`endif

    if (WIDTH < 2 || PAR_ODD < 0 || PAR_ODD > 1) begin : g_param_check
        $error("serial_word_deserializer: WIDTH must be >= 2 and PAR_ODD must be 0 or 1");
    end

    serial_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             shift_en;
    logic [WIDTH-1:0] word;

`ifdef SERIAL_PARITY_EN
    logic             par_acc_q, par_acc_d;
    logic             par_err_q, par_err_d;
`endif

    sipo_shift_core #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk      (clk),
        .clear    (clear),
        .shift_en (shift_en),
        .dir      (dir_q),
        .sin      (sin),
        .q        (word)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        // Clear first so a same-cycle error event below overrides it.
        frame_err_d  = frame_err_q & ~err_clr;
        overrun_d    = overrun_q & ~err_clr;
        shift_en     = 1'b0;
`ifdef SERIAL_PARITY_EN
        par_acc_d    = par_acc_q;
        par_err_d    = par_err_q & ~err_clr;
`endif

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        if (sin_en) begin
            unique case (state_q)
                IDLE: begin
                    if (sin == START_BIT) begin
                        state_d = DATA;
                        dir_d   = dir;
                        cnt_d   = '0;
`ifdef SERIAL_PARITY_EN
                        par_acc_d = 1'b0;
`endif
                    end
                end
                DATA: begin
                    shift_en = 1'b1;
`ifdef SERIAL_PARITY_EN
                    par_acc_d = par_acc_q ^ sin;
`endif
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = AFTER_DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef SERIAL_PARITY_EN
                PARITY: begin
                    state_d = STOP;
                    if (parity_mismatch(par_acc_q, sin, 1'(PAR_ODD))) begin
                        par_err_d = 1'b1;
                    end
                end
`endif
                STOP: begin
                    state_d = IDLE;
                    if (sin == STOP_BIT) begin
                        // Holding register is free if empty or drained on this same edge.
                        if (!dout_valid_q || dout_ready) begin
                            dout_d       = word;
                            dout_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dir_q        <= DIR_LSB_FIRST;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef SERIAL_PARITY_EN
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            par_acc_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            par_acc_q <= par_acc_d;
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
